mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_if.sv | 15 +
 rtl/mdu_core.sv | 37 +++
 rtl/mult_div_unit.sv | 48 ++++
 tb/tb_mult_div_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, latencies and launch decode for the multiply/divide unit.
// Define MDU_MADD_EN to make MADD/MSUB launch accumulating operations; otherwise they are no-ops.
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MADD, OP_MSUB
  } md_op_e;
  localparam int LAT_MUL = 5;
  localparam int LAT_DIV = 10;
  function automatic logic is_launch(md_op_e op);
`ifdef MDU_MADD_EN
    return op != OP_MTHI && op != OP_MTLO;
`else
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`endif
  endfunction
  function automatic logic [3:0] op_lat(md_op_e op);
    return (op == OP_DIV || op == OP_DIVU) ? 4'(LAT_DIV) : 4'(LAT_MUL);
  endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage request, stall and HI/LO read bundle of the multiply/divide unit.
interface mdu_if;
  import mdu_pkg::*;
  logic        start;
  md_op_e      md_op;
  logic        wr_en;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        m_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, md_op, wr_en, src_a, src_b, input busy, m_stall, hi, lo);
  modport slave (input start, md_op, wr_en, src_a, src_b, output busy, m_stall, hi, lo);
endinterface

// File: rtl/mdu_core.sv
// mdu_core: combinational multiply/divide/accumulate datapath producing a 64-bit {HI,LO} result.
module mdu_core
  import mdu_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] acc,
  output logic [63:0] res,
  output logic        dz
);
  logic               bz, ovf;
  logic [31:0]        d;
  logic signed [31:0] sa, sd;
  logic [63:0]        sprod, uprod;
  assign bz = b == '0;
  assign dz = bz && (op == OP_DIV || op == OP_DIVU);
  // a safe divisor keeps /0 and MIN/-1 well defined; MIN/-1 wraps to MIN remainder 0
  assign ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  assign d = bz ? 32'd1 : b;
  assign sa = a;
  assign sd = ovf ? 32'sd1 : d;
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'd0, a} * {32'd0, b};
  always_comb begin
    res = '0;
    case (op)
      OP_MULT:  res = sprod;
      OP_MULTU: res = uprod;
      OP_DIV:   res = {32'(sa % sd), 32'(sa / sd)};
      OP_DIVU:  res = {a % d, a / d};
      OP_MADD:  res = acc + sprod;
      OP_MSUB:  res = acc - sprod;
      default:  res = '0;
    endcase
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit with MTHI/MTLO writes and pipeline stall.
// MADD/MSUB are active only when MDU_MADD_EN is defined (see mdu_pkg).
module mult_div_unit
  import mdu_pkg::*;
(
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  logic [3:0]  cnt;
  logic [31:0] hi_q, lo_q, pend_hi, pend_lo;
  logic        pend_dz, busy, go, wr, dz;
  logic [63:0] res;
  mdu_core u_core (
    .op(bus.md_op), .a(bus.src_a), .b(bus.src_b), .acc({hi_q, lo_q}), .res(res), .dz(dz)
  );
  assign busy = cnt != '0;
  assign go = bus.start && !busy && is_launch(bus.md_op);
  assign wr = bus.wr_en && !bus.start && !busy && (bus.md_op == OP_MTHI || bus.md_op == OP_MTLO);
  assign bus.busy = busy;
  assign bus.m_stall = bus.start || busy;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  // result is computed at launch and held until the latency expires
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hi_q <= '0;
      lo_q <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
    end else if (go) begin
      cnt <= op_lat(bus.md_op);
      {pend_hi, pend_lo} <= res;
      pend_dz <= dz;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && !pend_dz) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
    end else if (wr) begin
      if (bus.md_op == OP_MTHI) hi_q <= bus.src_a;
      else lo_q <= bus.src_a;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table, directed corner sequences and random ops against an arithmetic model.
module tb_mult_div_unit;
  import mdu_pkg::*;
  typedef struct {
    string       nm;
    md_op_e      op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          lat;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] m;
  vec_t vt[$];
  mdu_if bus ();
  mult_div_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return 32'($urandom_range(0, 20));
    if (r == 1) return 32'(-int'($urandom_range(1, 20)));
    if (r == 2) return 32'd0;
    if (r == 3) return 32'h8000_0000;
    return $urandom;
  endfunction

  // architectural meaning of each op on the 64-bit {HI,LO} pair
  function automatic void ref_model(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                    inout logic [63:0] acc, output int lat);
    int ia, ib;
    longint sa, sb;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    lat = 0;
    case (op)
      OP_MULT:  begin acc = sa * sb; lat = 5; end
      OP_MULTU: begin acc = {32'd0, a} * {32'd0, b}; lat = 5; end
      OP_DIV:   begin lat = 10; if (b != 0) acc = {32'(sa % sb), 32'(sa / sb)}; end
      OP_DIVU:  begin lat = 10; if (b != 0) acc = {a % b, a / b}; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin acc = acc + 64'(sa * sb); lat = 5; end
      OP_MSUB:  begin acc = acc - 64'(sa * sb); lat = 5; end
`endif
      default:  lat = 0;
    endcase
  endfunction

  task automatic mt(input md_op_e op, input logic [31:0] val);
    bus.wr_en = 1'b1;
    bus.md_op = op;
    bus.src_a = val;
    tick;
    bus.wr_en = 1'b0;
    m = (op == OP_MTHI) ? {val, m[31:0]} : {m[63:32], val};
  endtask

  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input string nm);
    int cyc;
    logic bad;
    bus.start = 1'b1;
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    #1;
    check({nm, " m_stall at start"}, 64'(bus.m_stall), 64'd1);
    tick;
    bus.start = 1'b0;
    cyc = 0;
    bad = 1'b0;
    while (bus.busy === 1'b1 && cyc < 20) begin
      if ({bus.hi, bus.lo} !== m || bus.m_stall !== 1'b1) bad = 1'b1;
      cyc++;
      tick;
    end
    check({nm, " busy cycles"}, 64'(cyc), 64'(lat));
    check({nm, " old hi/lo and stall while busy"}, 64'(bad), 64'd0);
    check({nm, " hi/lo"}, {bus.hi, bus.lo}, exp);
    m = exp;
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    bus.md_op = OP_MULT;
    bus.src_a = '0;
    bus.src_b = '0;
    m = '0;
    vt.push_back('{"mult neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
    vt.push_back('{"multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 32'h1, 5});
    vt.push_back('{"mult min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h4000_0000, 32'h0, 5});
    vt.push_back('{"divu", OP_DIVU, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 10});
    vt.push_back('{"div neg dividend", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
    vt.push_back('{"div neg divisor", OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, 32'd1, 32'hFFFF_FFFD, 10});
    vt.push_back('{"div by zero", OP_DIV, 32'd5, 32'd0, 32'hAAAA, 32'h1234, 32'hAAAA, 32'h1234, 10});
    vt.push_back('{"divu by zero", OP_DIVU, 32'd9, 32'd0, 32'h55, 32'h66, 32'h55, 32'h66, 10});
`ifdef MDU_MADD_EN
    vt.push_back('{"madd carry", OP_MADD, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5});
    vt.push_back('{"msub wrap", OP_MSUB, 32'd1, 32'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5});
`else
    vt.push_back('{"madd disabled", OP_MADD, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 0});
    vt.push_back('{"msub disabled", OP_MSUB, 32'd1, 32'd1, 32'h3, 32'h4, 32'h3, 32'h4, 0});
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;

    foreach (vt[i]) begin
      mt(OP_MTHI, vt[i].pre_hi);
      mt(OP_MTLO, vt[i].pre_lo);
      run_op(vt[i].op, vt[i].a, vt[i].b, {vt[i].exp_hi, vt[i].exp_lo}, vt[i].lat, vt[i].nm);
    end

    mt(OP_MTHI, 32'hCAFE_F00D);
    check("mthi busy", 64'(bus.busy), 64'd0);
    check("mthi value", {bus.hi, bus.lo}, m);
    mt(OP_MTLO, 32'h0BAD_BEEF);
    check("mtlo value", {bus.hi, bus.lo}, m);

    // requests arriving while busy are dropped
    bus.start = 1'b1;
    bus.md_op = OP_MULT;
    bus.src_a = 32'd7;
    bus.src_b = 32'd6;
    tick;
    bus.start = 1'b0;
    tick;
    bus.wr_en = 1'b1;
    bus.start = 1'b1;
    bus.md_op = OP_MTHI;
    bus.src_a = 32'hDEAD;
    tick;
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    cyc = 2;
    while (bus.busy === 1'b1 && cyc < 20) begin
      cyc++;
      tick;
    end
    check("busy-ignore cycles", 64'(cyc), 64'd5);
    check("busy-ignore hi/lo", {bus.hi, bus.lo}, 64'd42);
    m = 64'd42;

    // start beats a simultaneous write
    bus.wr_en = 1'b1;
    run_op(OP_MULT, 32'd2, 32'd3, 64'd6, 5, "start+wr");
    bus.wr_en = 1'b0;
    bus.start = 1'b1;
    bus.wr_en = 1'b1;
    bus.md_op = OP_MTLO;
    bus.src_a = 32'h55;
    tick;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check("start+mtlo dropped", {bus.hi, bus.lo}, m);
    check("start+mtlo busy", 64'(bus.busy), 64'd0);

    // reset mid-divide aborts with no later update
    mt(OP_MTHI, 32'h11);
    mt(OP_MTLO, 32'h22);
    bus.start = 1'b1;
    bus.md_op = OP_DIVU;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mid reset busy", 64'(bus.busy), 64'd0);
    check("mid reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    repeat (12) tick;
    check("after abort hi/lo", {bus.hi, bus.lo}, 64'd0);
    m = '0;

    // reset outranks start
    reset = 1'b1;
    bus.start = 1'b1;
    bus.md_op = OP_MULT;
    tick;
    bus.start = 1'b0;
    reset = 1'b0;
    check("reset vs start busy", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 60; i++) begin
      md_op_e op;
      logic [31:0] a, b;
      logic [63:0] e;
      int lat;
      op = md_op_e'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if (op == OP_MTHI || op == OP_MTLO) begin
        mt(op, a);
        check("rand move", {bus.hi, bus.lo}, m);
      end else begin
        e = m;
        ref_model(op, a, b, e, lat);
        run_op(op, a, b, e, lat, $sformatf("rand %0d op %0d", i, op));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
